tcp_rx_ack_tracker: RTL and testbench
=====================================

Name: tcp_rx_ack_tracker

Overview:
- Per-flow peer-ACK tracker sitting directly after RX header parse in the TCP slow path; produces the `their_ack_num`, `their_win_size` and dup-ACK count fields of the per-flow RX state.
- Classifies each incoming ACK as advancing, duplicate, window-update or stale.
- Counts consecutive duplicate ACKs; issues one fast-retransmit request to the TX engine when the count reaches the threshold.
- Exposes a registered state read port for the TX scheduler.

Parameters:
- MAX_FLOW_CNT, 4, number of tracked flows
- FLOWID_W, 2, clog2(MAX_FLOW_CNT)
- ACK_NUM_W, 32, ACK/sequence width
- WIN_SIZE_W, 16, advertised window width
- DUP_ACK_CNT_W, 4, dup-ACK counter width
- DUP_ACK_RT, 3, dup count that triggers retransmit

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- init_val  in  1  (re)initialise flow state
- init_flowid  in  FLOWID_W  flow to initialise
- init_ack_num  in  ACK_NUM_W  initial their_ack_num (peer ISN+1)
- init_win_size  in  WIN_SIZE_W  initial window
- ack_val  in  1  ACK event valid
- ack_rdy  out  1  ACK event accepted when ack_val&ack_rdy
- ack_flowid  in  FLOWID_W  event flow
- ack_num  in  ACK_NUM_W  ACK field of segment
- ack_win_size  in  WIN_SIZE_W  window field
- ack_payload_len  in  16  segment payload bytes
- rt_val  out  1  fast-retransmit request valid
- rt_rdy  in  1  TX engine accepts request
- rt_flowid  out  FLOWID_W  flow to retransmit
- rt_ack_num  out  ACK_NUM_W  seq to retransmit from
- rd_req_val  in  1  state read request
- rd_req_flowid  in  FLOWID_W  flow to read
- rd_resp_val  out  1  read response, 1 cycle after rd_req_val
- rd_resp_ack_num  out  ACK_NUM_W  their_ack_num
- rd_resp_win_size  out  WIN_SIZE_W  their_win_size
- rd_resp_dup_cnt  out  DUP_ACK_CNT_W  current dup count
- rt_trigger_cnt  out  32  total retransmit requests issued, wraps

Behaviour:
- State storage:
  - Flop array per flow: `vld`, `ack_num`, `win_size`, `dup_cnt`.
  - Reset: all fields 0; rt_val=0, rd_resp_val=0, rt_trigger_cnt=0, all other outputs 0.
- Init:
  - Sets `vld`=1, ack_num/win_size from inputs, dup_cnt=0 at the next edge.
  - Takes priority: ack_rdy=0 while init_val=1.
- ack_rdy = ~init_val & (~rt_val | rt_rdy).
- Accepted ACK is processed in the same cycle; state is written at the next edge, so back-to-back same-flow ACKs see updated state with no hazard.
- diff = ack_num − stored ack_num, modulo 2^ACK_NUM_W. Classification, first match wins:
  - flow not `vld`: drop, no state change.
  - diff[MSB]=0 and diff≠0 (advance): ack_num←ack_num, win←ack_win_size, dup_cnt←0.
  - diff=0, payload_len=0, ack_win_size equal to stored (duplicate): dup_cnt←dup_cnt+1, saturating at all-ones.
  - diff=0 otherwise (window update / data carrying): win←ack_win_size; dup_cnt unchanged.
  - diff[MSB]=1 (stale): drop.
- Retransmit trigger:
  - Fires only when the new dup_cnt equals DUP_ACK_RT exactly; further dups never re-trigger until an advance clears the count.
  - On trigger, next edge: rt_val=1, rt_flowid, rt_ack_num=stored ack_num; rt_trigger_cnt+1.
  - rt_* held stable until rt_val&rt_rdy.
  - Same-cycle accept with rt_rdy=1: new request replaces the drained one, rt_val stays 1.
- Read port:
  - rd_resp_* registered from the array one cycle after rd_req_val.
  - Concurrent write to the same flow: response returns the pre-write value.
  - rd_resp_val=0 when no request.
- Reset mid-operation:
  - Pending rt request discarded; all flows invalid.
  - ACKs dropped until re-init.

Test Plan:
- Init flow 1 ack=1000, win=512; ACKs 1000/win512/len0 ×3 → dup_cnt 1,2,3; rt_val=1, rt_flowid=1, rt_ack_num=1000 one cycle after third accept; rt_trigger_cnt=1; fourth dup → cnt=4, no new rt.
- Flow 1 dup_cnt=2, then ACK 1500 → ack_num=1500, dup_cnt=0; three dups at 1500 → rt_ack_num=1500.
- Wrap: init ack=0xFFFF_FFF0; ACK 0x0000_0010 → advance; subsequent ACK 0xFFFF_FFF8 → stale, state unchanged.
- Hold rt_rdy=0 with rt_val=1; offer ACK → ack_rdy=0, no accept; raise rt_rdy → request drains, ACK accepted same cycle.
- ACK ack=equal, win 512→1024 or len=100 → win updated, dup_cnt unchanged; ACK on uninitialised flow 3 → dropped, rd of flow 3 returns zeros.
- init_val and ack_val together for flow 2 → ack_rdy=0, init applied; assert rst_n low with rt_val=1 → rt_val=0, rt_trigger_cnt=0 immediately.

Source files
------------

// File: rtl/tcp_rx_ack_tracker.sv
// ---------------------------------------------------------------------------
// tcp_rx_ack_tracker
//
// Per-flow tracker for the peer's ACK stream, placed directly after RX header
// parse in the TCP slow path. For each flow it keeps the peer's cumulative
// ACK number, the last advertised window and a count of consecutive duplicate
// ACKs. Each accepted ACK is classified as advancing, duplicate,
// window-update or stale. When the duplicate count reaches DUP_ACK_RT, one
// fast-retransmit request is raised towards the TX engine.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   init_*                (re)initialise one flow; has priority over ACKs
//   ack_val/ack_rdy       ACK event handshake, plus flow id, ACK number,
//   ack_*                 window and payload length of the segment
//   rt_val/rt_rdy         fast-retransmit request handshake, plus flow id
//   rt_flowid/rt_ack_num  and the sequence number to resend from
//   rd_req_*              state read request (flow id)
//   rd_resp_*             registered read response, one cycle after request
//   rt_trigger_cnt        running total of retransmit requests (wraps)
// ---------------------------------------------------------------------------
module tcp_rx_ack_tracker #(
  parameter int MAX_FLOW_CNT  = 4,
  parameter int FLOWID_W      = 2,
  parameter int ACK_NUM_W     = 32,
  parameter int WIN_SIZE_W    = 16,
  parameter int DUP_ACK_CNT_W = 4,
  parameter int DUP_ACK_RT    = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     init_val,
  input  logic [FLOWID_W-1:0]      init_flowid,
  input  logic [ACK_NUM_W-1:0]     init_ack_num,
  input  logic [WIN_SIZE_W-1:0]    init_win_size,

  input  logic                     ack_val,
  output logic                     ack_rdy,
  input  logic [FLOWID_W-1:0]      ack_flowid,
  input  logic [ACK_NUM_W-1:0]     ack_num,
  input  logic [WIN_SIZE_W-1:0]    ack_win_size,
  input  logic [15:0]              ack_payload_len,

  output logic                     rt_val,
  input  logic                     rt_rdy,
  output logic [FLOWID_W-1:0]      rt_flowid,
  output logic [ACK_NUM_W-1:0]     rt_ack_num,

  input  logic                     rd_req_val,
  input  logic [FLOWID_W-1:0]      rd_req_flowid,
  output logic                     rd_resp_val,
  output logic [ACK_NUM_W-1:0]     rd_resp_ack_num,
  output logic [WIN_SIZE_W-1:0]    rd_resp_win_size,
  output logic [DUP_ACK_CNT_W-1:0] rd_resp_dup_cnt,

  output logic [31:0]              rt_trigger_cnt
);

  // Per-flow state array
  logic                     vld_q [MAX_FLOW_CNT];
  logic [ACK_NUM_W-1:0]     ack_q [MAX_FLOW_CNT];
  logic [WIN_SIZE_W-1:0]    win_q [MAX_FLOW_CNT];
  logic [DUP_ACK_CNT_W-1:0] dup_q [MAX_FLOW_CNT];

  logic                     ack_fire;
  logic                     cur_vld;
  logic [ACK_NUM_W-1:0]     cur_ack;
  logic [WIN_SIZE_W-1:0]    cur_win;
  logic [DUP_ACK_CNT_W-1:0] cur_dup;
  logic [ACK_NUM_W-1:0]     diff;
  logic [DUP_ACK_CNT_W-1:0] dup_inc;
  logic                     is_adv;
  logic                     is_dup;
  logic                     is_wupd;
  logic                     rt_fire;

  // An ACK can only be taken when no init is in flight and the retransmit
  // slot is free or draining this cycle, so a trigger never overwrites a
  // request the TX engine has not yet seen.
  assign ack_rdy  = ~init_val & (~rt_val | rt_rdy);
  assign ack_fire = ack_val & ack_rdy;

  assign cur_vld = vld_q[ack_flowid];
  assign cur_ack = ack_q[ack_flowid];
  assign cur_win = win_q[ack_flowid];
  assign cur_dup = dup_q[ack_flowid];

  // Modular distance handles sequence-space wrap; MSB set means "behind".
  assign diff = ack_num - cur_ack;

  // Saturating increment so a long dup storm cannot wrap the count back
  // through DUP_ACK_RT and re-trigger.
  assign dup_inc = (cur_dup == '1) ? cur_dup : cur_dup + DUP_ACK_CNT_W'(1);

  // Classify the accepted ACK; stale ACKs and invalid flows fall through
  // with every flag low, which leaves the state untouched.
  always_comb begin
    is_adv  = 1'b0;
    is_dup  = 1'b0;
    is_wupd = 1'b0;
    if (ack_fire && cur_vld) begin
      if (!diff[ACK_NUM_W-1] && (diff != '0)) begin
        is_adv = 1'b1;
      end else if (diff == '0) begin
        if ((ack_payload_len == 16'd0) && (ack_win_size == cur_win))
          is_dup = 1'b1;
        else
          is_wupd = 1'b1;
      end
    end
  end

  // Only the exact crossing into the threshold fires.
  assign rt_fire = is_dup && (dup_inc == DUP_ACK_CNT_W'(DUP_ACK_RT));

  // Per-flow state update: init wins, otherwise the classified ACK
  // updates its flow. Init and an accepted ACK never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_FLOW_CNT; i++) begin
        vld_q[i] <= 1'b0;
        ack_q[i] <= '0;
        win_q[i] <= '0;
        dup_q[i] <= '0;
      end
    end else if (init_val) begin
      vld_q[init_flowid] <= 1'b1;
      ack_q[init_flowid] <= init_ack_num;
      win_q[init_flowid] <= init_win_size;
      dup_q[init_flowid] <= '0;
    end else if (is_adv) begin
      ack_q[ack_flowid] <= ack_num;
      win_q[ack_flowid] <= ack_win_size;
      dup_q[ack_flowid] <= '0;
    end else if (is_dup) begin
      dup_q[ack_flowid] <= dup_inc;
    end else if (is_wupd) begin
      win_q[ack_flowid] <= ack_win_size;
    end
  end

  // Retransmit request register. A new trigger loads the request (which may
  // replace one draining in the same cycle); otherwise an accepted request
  // clears rt_val and the fields hold their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rt_val         <= 1'b0;
      rt_flowid      <= '0;
      rt_ack_num     <= '0;
      rt_trigger_cnt <= '0;
    end else if (rt_fire) begin
      rt_val         <= 1'b1;
      rt_flowid      <= ack_flowid;
      rt_ack_num     <= cur_ack;
      rt_trigger_cnt <= rt_trigger_cnt + 32'd1;
    end else if (rt_val && rt_rdy) begin
      rt_val <= 1'b0;
    end
  end

  // Read port samples the array before this edge's write, so a concurrent
  // update to the same flow returns the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_resp_val      <= 1'b0;
      rd_resp_ack_num  <= '0;
      rd_resp_win_size <= '0;
      rd_resp_dup_cnt  <= '0;
    end else begin
      rd_resp_val <= rd_req_val;
      if (rd_req_val) begin
        rd_resp_ack_num  <= ack_q[rd_req_flowid];
        rd_resp_win_size <= win_q[rd_req_flowid];
        rd_resp_dup_cnt  <= dup_q[rd_req_flowid];
      end
    end
  end

endmodule

// File: tb/tb_tcp_rx_ack_tracker.sv
// ---------------------------------------------------------------------------
// tb_tcp_rx_ack_tracker
//
// Directed bench for tcp_rx_ack_tracker: a table of per-cycle stimulus
// records with hand-computed expected outputs, followed by a hand-written
// asynchronous reset sequence taken while a retransmit request is pending.
// ---------------------------------------------------------------------------
module tb_tcp_rx_ack_tracker;

  logic        clk;
  logic        rst_n;
  logic        init_val;
  logic [1:0]  init_flowid;
  logic [31:0] init_ack_num;
  logic [15:0] init_win_size;
  logic        ack_val;
  logic        ack_rdy;
  logic [1:0]  ack_flowid;
  logic [31:0] ack_num;
  logic [15:0] ack_win_size;
  logic [15:0] ack_payload_len;
  logic        rt_val;
  logic        rt_rdy;
  logic [1:0]  rt_flowid;
  logic [31:0] rt_ack_num;
  logic        rd_req_val;
  logic [1:0]  rd_req_flowid;
  logic        rd_resp_val;
  logic [31:0] rd_resp_ack_num;
  logic [15:0] rd_resp_win_size;
  logic [3:0]  rd_resp_dup_cnt;
  logic [31:0] rt_trigger_cnt;

  int checks;
  int passes;

  tcp_rx_ack_tracker dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .init_val         (init_val),
    .init_flowid      (init_flowid),
    .init_ack_num     (init_ack_num),
    .init_win_size    (init_win_size),
    .ack_val          (ack_val),
    .ack_rdy          (ack_rdy),
    .ack_flowid       (ack_flowid),
    .ack_num          (ack_num),
    .ack_win_size     (ack_win_size),
    .ack_payload_len  (ack_payload_len),
    .rt_val           (rt_val),
    .rt_rdy           (rt_rdy),
    .rt_flowid        (rt_flowid),
    .rt_ack_num       (rt_ack_num),
    .rd_req_val       (rd_req_val),
    .rd_req_flowid    (rd_req_flowid),
    .rd_resp_val      (rd_resp_val),
    .rd_resp_ack_num  (rd_resp_ack_num),
    .rd_resp_win_size (rd_resp_win_size),
    .rd_resp_dup_cnt  (rd_resp_dup_cnt),
    .rt_trigger_cnt   (rt_trigger_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One record per clock cycle: inputs, then expected outputs. Expected
  // rt_* / counter / rd_resp_* values are those seen just after the edge.
  typedef struct {
    logic [31:0] iv, ifl, ian, iwin;
    logic [31:0] av, afl, an, awin, alen;
    logic [31:0] rtr, rv, rfl;
    logic [31:0] e_ardy, e_rtv, e_rtf, e_rta, e_cnt;
    logic [31:0] e_rdv, e_rda, e_rdw, e_rdd;
  } vec_t;

  vec_t vecs[$];

  // Builds one record; arguments follow the struct field order.
  function automatic vec_t mk(
    input logic [31:0] iv, ifl, ian, iwin,
    input logic [31:0] av, afl, an, awin, alen,
    input logic [31:0] rtr, rv, rfl,
    input logic [31:0] e_ardy, e_rtv, e_rtf, e_rta, e_cnt,
    input logic [31:0] e_rdv, e_rda, e_rdw, e_rdd);
    vec_t v;
    v.iv = iv; v.ifl = ifl; v.ian = ian; v.iwin = iwin;
    v.av = av; v.afl = afl; v.an = an; v.awin = awin; v.alen = alen;
    v.rtr = rtr; v.rv = rv; v.rfl = rfl;
    v.e_ardy = e_ardy; v.e_rtv = e_rtv; v.e_rtf = e_rtf;
    v.e_rta = e_rta; v.e_cnt = e_cnt;
    v.e_rdv = e_rdv; v.e_rda = e_rda; v.e_rdw = e_rdw; v.e_rdd = e_rdd;
    return v;
  endfunction

  // Drive one record's inputs onto the DUT.
  task automatic applyStimulus(input vec_t v);
    init_val        = v.iv[0];
    init_flowid     = v.ifl[1:0];
    init_ack_num    = v.ian;
    init_win_size   = v.iwin[15:0];
    ack_val         = v.av[0];
    ack_flowid      = v.afl[1:0];
    ack_num         = v.an;
    ack_win_size    = v.awin[15:0];
    ack_payload_len = v.alen[15:0];
    rt_rdy          = v.rtr[0];
    rd_req_val      = v.rv[0];
    rd_req_flowid   = v.rfl[1:0];
  endtask

  // Single comparison; every call counts toward the summary.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t idle(input logic [31:0] rtr);
    return mk(0,0,0,0, 0,0,0,0,0, rtr,0,0, 1,0,0,0,0, 0,0,0,0);
  endfunction

  initial begin
    checks = 0;
    passes = 0;
    rst_n  = 1'b0;
    applyStimulus(idle(1));

    // Stimulus table. Columns:
    //   iv ifl ian iwin | av afl an awin alen | rtr rv rfl |
    //   e_ardy e_rtv e_rtf e_rta e_cnt | e_rdv e_rda e_rdw e_rdd
    // Flow 1: three dups trigger, held request blocks ACKs, fourth dup quiet
    vecs.push_back(mk(1,1,1000,512, 0,0,0,0,0,       1,0,0, 0,0,0,0,0,       0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      1,1,1000,512,0,  1,0,0, 1,0,0,0,0,       0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      1,1,1000,512,0,  1,1,1, 1,0,0,0,0,       1,1000,512,1));
    vecs.push_back(mk(0,0,0,0,      1,1,1000,512,0,  0,0,0, 1,1,1,1000,1,    0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      1,1,1000,512,0,  0,1,1, 0,1,1,1000,1,    1,1000,512,3));
    vecs.push_back(mk(0,0,0,0,      1,1,1000,512,0,  1,0,0, 1,0,0,0,1,       0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      0,0,0,0,0,       1,1,1, 1,0,0,0,1,       1,1000,512,4));
    // Re-init flow 1, set up flow 2 with two dups, advance flow 1 to 1500
    vecs.push_back(mk(1,1,1000,512, 0,0,0,0,0,       1,0,0, 0,0,0,0,1,       0,0,0,0));
    vecs.push_back(mk(1,2,5000,100, 0,0,0,0,0,       1,0,0, 0,0,0,0,1,       0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      1,1,1000,512,0,  1,0,0, 1,0,0,0,1,       0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      1,1,1000,512,0,  1,0,0, 1,0,0,0,1,       0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      1,2,5000,100,0,  1,0,0, 1,0,0,0,1,       0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      1,2,5000,100,0,  1,0,0, 1,0,0,0,1,       0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      1,1,1500,600,0,  1,1,1, 1,0,0,0,1,       1,1000,512,2));
    vecs.push_back(mk(0,0,0,0,      0,0,0,0,0,       1,1,1, 1,0,0,0,1,       1,1500,600,0));
    vecs.push_back(mk(0,0,0,0,      1,1,1500,600,0,  1,0,0, 1,0,0,0,1,       0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      1,1,1500,600,0,  1,0,0, 1,0,0,0,1,       0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      1,1,1500,600,0,  1,0,0, 1,1,1,1500,2,    0,0,0,0));
    // Flow 2 third dup while flow 1 request drains: replaced, rt_val stays 1
    vecs.push_back(mk(0,0,0,0,      1,2,5000,100,0,  1,0,0, 1,1,2,5000,3,    0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      0,0,0,0,0,       1,0,0, 1,0,0,0,3,       0,0,0,0));
    // Flow 0 across sequence wrap, then a stale ACK
    vecs.push_back(mk(1,0,32'hFFFF_FFF0,64, 0,0,0,0,0,        1,0,0, 0,0,0,0,3, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      1,0,32'h10,70,0,           1,0,0, 1,0,0,0,3, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      0,0,0,0,0,                 1,1,0, 1,0,0,0,3, 1,32'h10,70,0));
    vecs.push_back(mk(0,0,0,0,      1,0,32'hFFFF_FFF8,99,0,    1,0,0, 1,0,0,0,3, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      0,0,0,0,0,                 1,1,0, 1,0,0,0,3, 1,32'h10,70,0));
    // Flow 2 window update, data-carrying segment, then a dup past threshold
    vecs.push_back(mk(0,0,0,0,      1,2,5000,200,0,  1,0,0, 1,0,0,0,3,       0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      0,0,0,0,0,       1,1,2, 1,0,0,0,3,       1,5000,200,3));
    vecs.push_back(mk(0,0,0,0,      1,2,5000,250,100,1,0,0, 1,0,0,0,3,       0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      0,0,0,0,0,       1,1,2, 1,0,0,0,3,       1,5000,250,3));
    vecs.push_back(mk(0,0,0,0,      1,2,5000,250,0,  1,0,0, 1,0,0,0,3,       0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      0,0,0,0,0,       1,1,2, 1,0,0,0,3,       1,5000,250,4));
    // Uninitialised flow 3 drops its ACK and reads back zeros
    vecs.push_back(mk(0,0,0,0,      1,3,1234,10,0,   1,0,0, 1,0,0,0,3,       0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      0,0,0,0,0,       1,1,3, 1,0,0,0,3,       1,0,0,0));
    // Init and ACK together on flow 2: init wins, ACK not accepted
    vecs.push_back(mk(1,2,7000,300, 1,2,7100,300,0,  1,0,0, 0,0,0,0,3,       0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      0,0,0,0,0,       1,1,2, 1,0,0,0,3,       1,7000,300,0));
    // Flow 2 triggers again and the request is left pending
    vecs.push_back(mk(0,0,0,0,      1,2,7000,300,0,  1,0,0, 1,0,0,0,3,       0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      1,2,7000,300,0,  1,0,0, 1,0,0,0,3,       0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      1,2,7000,300,0,  0,0,0, 1,1,2,7000,4,    0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      0,0,0,0,0,       0,0,0, 0,1,2,7000,4,    0,0,0,0));

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset rt_val", 32'(rt_val), 0);
    checkOutput("reset rd_resp_val", 32'(rd_resp_val), 0);
    checkOutput("reset rt_trigger_cnt", rt_trigger_cnt, 0);
    checkOutput("reset ack_rdy", 32'(ack_rdy), 1);

    // Table-driven section
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d ack_rdy", i), 32'(ack_rdy), vecs[i].e_ardy);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d rt_val", i), 32'(rt_val), vecs[i].e_rtv);
      if (vecs[i].e_rtv[0]) begin
        checkOutput($sformatf("v%0d rt_flowid", i), 32'(rt_flowid), vecs[i].e_rtf);
        checkOutput($sformatf("v%0d rt_ack_num", i), rt_ack_num, vecs[i].e_rta);
      end
      checkOutput($sformatf("v%0d rt_trigger_cnt", i), rt_trigger_cnt, vecs[i].e_cnt);
      checkOutput($sformatf("v%0d rd_resp_val", i), 32'(rd_resp_val), vecs[i].e_rdv);
      if (vecs[i].e_rdv[0]) begin
        checkOutput($sformatf("v%0d rd_ack_num", i), rd_resp_ack_num, vecs[i].e_rda);
        checkOutput($sformatf("v%0d rd_win_size", i), 32'(rd_resp_win_size), vecs[i].e_rdw);
        checkOutput($sformatf("v%0d rd_dup_cnt", i), 32'(rd_resp_dup_cnt), vecs[i].e_rdd);
      end
    end

    // Asynchronous reset between edges with a request pending: clears at once
    @(negedge clk);
    applyStimulus(idle(0));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async rst rt_val", 32'(rt_val), 0);
    checkOutput("async rst rt_trigger_cnt", rt_trigger_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Previously valid flow 1 must now drop its ACK
    @(negedge clk);
    applyStimulus(mk(0,0,0,0, 1,1,2000,512,0, 1,0,0, 1,0,0,0,0, 0,0,0,0));
    #1;
    checkOutput("post rst ack_rdy", 32'(ack_rdy), 1);
    @(negedge clk);
    applyStimulus(mk(0,0,0,0, 0,0,0,0,0, 1,1,1, 1,0,0,0,0, 1,0,0,0));
    @(posedge clk);
    #1;
    checkOutput("post rst rd_resp_val", 32'(rd_resp_val), 1);
    checkOutput("post rst rd_ack_num", rd_resp_ack_num, 0);
    checkOutput("post rst rd_win_size", 32'(rd_resp_win_size), 0);
    checkOutput("post rst rd_dup_cnt", 32'(rd_resp_dup_cnt), 0);
    checkOutput("post rst rt_val", 32'(rt_val), 0);
    @(negedge clk);
    applyStimulus(idle(1));
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
